instr_prefetch: RTL and testbench

- Fetch stage directly downstream of the SPI program memory. Drives the memory's 10-bit word address, captures each returned 16-bit instruction, and buffers it in a small FIFO.
- Presents instructions to the decoder with a valid/ready handshake.
- Handles branch redirects, flushing, and the memory's "refetch only on address change" protocol.

---
 rtl/instr_prefetch_pkg.sv | 20 ++
 rtl/instr_prefetch_fifo.sv | 43 ++++
 rtl/instr_prefetch.sv | 101 ++++++++++
 tb/tb_instr_prefetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the instruction
// prefetch stage.
package instr_prefetch_pkg;
  localparam int AW = 10;
  localparam int IW = 16;
  localparam int EW = IW + AW;
  localparam logic [AW-1:0] MEM_IDLE_ADDR_DEF = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DUMMY   = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the
// storage registers so it is valid the cycle after the push.
module instr_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_prefetch.sv
// Fetch stage: drives the SPI program memory address, buffers returned
// words in a FIFO and serves them to the decoder with valid/ready.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int            DEPTH         = 4,
  parameter logic [AW-1:0] RESET_PC      = 10'h000,
  parameter logic [AW-1:0] MEM_IDLE_ADDR = MEM_IDLE_ADDR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  input  logic [IW-1:0] mem_instr,
  input  logic          mem_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic [AW-1:0] fetch_pc, mem_last;
  logic [IW-1:0] copy_instr;
  logic          copy_valid;
  logic [CW-1:0] count;
  logic          push, pop, in_flight, can_issue, hit, done;
  fetch_entry_t  push_entry, head;

  assign in_flight = (state != S_IDLE);
  assign done      = in_flight && mem_ready;
  assign hit       = (fetch_pc == mem_last);
  assign can_issue = (state == S_IDLE) && !redirect && (count < CW'(DEPTH));
  assign pop       = out_valid && out_ready;

  // The memory only re-reads on an address change, so a repeat of the last
  // completed address is served from the captured copy.
  always_comb begin
    push       = 1'b0;
    push_entry = '{instr: copy_instr, pc: fetch_pc};
    if (state == S_WAIT && mem_ready && !redirect) begin
      push       = 1'b1;
      push_entry = '{instr: mem_instr, pc: mem_addr};
    end else if (can_issue && hit && copy_valid) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mem_addr   <= MEM_IDLE_ADDR;
      mem_last   <= MEM_IDLE_ADDR;
      fetch_pc   <= RESET_PC;
      copy_instr <= '0;
      copy_valid <= 1'b0;
    end else begin
      if (done) begin
        mem_last   <= mem_addr;
        copy_instr <= mem_instr;
        copy_valid <= 1'b1;
        state      <= S_IDLE;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        if (state == S_WAIT && !mem_ready) state <= S_DISCARD;
      end else if (done) begin
        if (state == S_WAIT) fetch_pc <= fetch_pc + 1'b1;
      end else if (can_issue) begin
        if (!hit) begin
          mem_addr <= fetch_pc;
          state    <= S_WAIT;
        end else if (copy_valid) begin
          fetch_pc <= fetch_pc + 1'b1;
        end else begin
          // Force a throwaway read of a neighbour so the target becomes
          // an address change the memory will actually fetch.
          mem_addr <= {fetch_pc[AW-1:1], ~fetch_pc[0]};
          state    <= S_DUMMY;
        end
      end
    end
  end

  instr_prefetch_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench: memory model with variable latency plus an in-order
// PC scoreboard for two instances (RESET_PC 0x000 and 0x3FF).
module tb_instr_prefetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  mem_addr    [2];
  logic [15:0] mem_instr   [2];
  logic        mem_ready   [2];
  logic        redirect    [2];
  logic [9:0]  redirect_pc [2];
  logic        out_valid   [2];
  logic [15:0] out_instr   [2];
  logic [9:0]  out_pc      [2];
  logic        out_ready   [2];

  instr_prefetch #(.DEPTH(4), .RESET_PC(10'h000), .MEM_IDLE_ADDR(10'h3FF)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr[0]), .mem_instr(mem_instr[0]),
    .mem_ready(mem_ready[0]), .redirect(redirect[0]), .redirect_pc(redirect_pc[0]),
    .out_valid(out_valid[0]), .out_instr(out_instr[0]), .out_pc(out_pc[0]),
    .out_ready(out_ready[0]));

  instr_prefetch #(.DEPTH(4), .RESET_PC(10'h3FF), .MEM_IDLE_ADDR(10'h3FF)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr[1]), .mem_instr(mem_instr[1]),
    .mem_ready(mem_ready[1]), .redirect(redirect[1]), .redirect_pc(redirect_pc[1]),
    .out_valid(out_valid[1]), .out_instr(out_instr[1]), .out_pc(out_pc[1]),
    .out_ready(out_ready[1]));

  int n_checks = 0, n_pass = 0;
  int lat_min = 1, lat_max = 4;
  int proto_err = 0;
  int n_hs = 0;
  int n_reads [2] = '{0, 0};
  logic [9:0] m_last [2], m_addr [2];
  logic       m_busy [2];
  int         m_cnt  [2];
  logic [9:0] exp_pc [2];

  function automatic logic [15:0] rom(input logic [9:0] a);
    return (16'(a) * 16'd41) ^ 16'hC35A;
  endfunction

  // Memory: starts a read whenever the address differs from the last one
  // completed, and flags any address change while busy.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mem_ready[k] <= 1'b0;
      if (rst) begin
        m_last[k] <= 10'h3FF;
        m_busy[k] <= 1'b0;
        m_cnt[k]  <= 0;
      end else if (m_busy[k]) begin
        if (mem_addr[k] !== m_addr[k]) proto_err <= proto_err + 1;
        if (m_cnt[k] == 0) begin
          mem_ready[k] <= 1'b1;
          mem_instr[k] <= rom(m_addr[k]);
          m_last[k]    <= m_addr[k];
          m_busy[k]    <= 1'b0;
          n_reads[k]   <= n_reads[k] + 1;
        end else begin
          m_cnt[k] <= m_cnt[k] - 1;
        end
      end else if (mem_addr[k] !== m_last[k]) begin
        m_busy[k] <= 1'b1;
        m_addr[k] <= mem_addr[k];
        m_cnt[k]  <= int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  // Every accepted instruction must be the next sequential PC since the last
  // reset/redirect, carrying that PC's memory contents.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [9:0] e;
      e = exp_pc[k];
      if (rst) begin
        e = (k == 0) ? 10'h000 : 10'h3FF;
      end else begin
        if (out_valid[k] && out_ready[k]) begin
          n_checks++;
          if (out_pc[k] !== e || out_instr[k] !== rom(e))
            $display("FAIL stream%0d: got pc %h instr %h, want pc %h instr %h",
                     k, out_pc[k], out_instr[k], e, rom(e));
          else n_pass++;
          e = e + 10'd1;
          n_hs++;
        end
        if (redirect[k]) e = redirect_pc[k];
      end
      exp_pc[k] <= e;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect[0] = 1'b0; redirect[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready(input int k, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mem_ready[k]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_addr(input int k, input logic [9:0] a, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mem_addr[k] === a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (mem_addr[k] !== 10'h3FF)
        $display("FAIL reset_mem_addr%0d: got %h want 3ff", k, mem_addr[k]);
      else n_pass++;
      n_checks++;
      if ({out_valid[k], out_instr[k], out_pc[k]} !== 27'h0)
        $display("FAIL reset_out%0d: got v%b i%h pc%h want all zero",
                 k, out_valid[k], out_instr[k], out_pc[k]);
      else n_pass++;
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_stream();
    bit ok;
    lat_min = 80; lat_max = 80;
    out_ready[0] = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_ready(0, 200, ok);
      n_checks++;
      if (!ok || mem_addr[0] !== 10'(i) || out_valid[0] !== 1'b0)
        $display("FAIL stream_addr%0d: got ok%b addr %h v%b want ok1 addr %h v0",
                 i, ok, mem_addr[0], out_valid[0], 10'(i));
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (out_valid[0] !== 1'b1 || out_pc[0] !== 10'(i) || out_instr[0] !== rom(10'(i)))
        $display("FAIL stream_out%0d: got v%b pc %h instr %h want v1 pc %h instr %h",
                 i, out_valid[0], out_pc[0], out_instr[0], 10'(i), rom(10'(i)));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0, h0;
    lat_min = 1; lat_max = 5;
    out_ready[0] = 1'b0;
    do_reset();
    r0 = n_reads[0];
    repeat (80) @(negedge clk);
    n_checks++;
    if (n_reads[0] - r0 != 4 || mem_addr[0] !== 10'd3)
      $display("FAIL bp_stall: got reads %0d addr %h want reads 4 addr 003",
               n_reads[0] - r0, mem_addr[0]);
    else n_pass++;
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_pc[0] !== 10'd0)
      $display("FAIL bp_head: got v%b pc %h want v1 pc 000", out_valid[0], out_pc[0]);
    else n_pass++;
    h0 = n_hs;
    @(posedge clk); #1 out_ready[0] = 1'b1;
    wait_addr(0, 10'd4, 5, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_resume: got addr %h want 004", mem_addr[0]);
    else n_pass++;
    repeat (60) @(negedge clk);
    n_checks++;
    if (n_hs - h0 < 8) $display("FAIL bp_progress: got %0d handshakes want >=8", n_hs - h0);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit ok, held;
    lat_min = 19; lat_max = 19;
    out_ready[0] = 1'b1;
    do_reset();
    wait_addr(0, 10'd2, 200, ok);
    @(posedge clk); #1 redirect[0] = 1'b1; redirect_pc[0] = 10'h100;
    @(posedge clk); #1 redirect[0] = 1'b0;
    held = ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_addr[0] !== 10'd2) held = 1'b0;
      if (mem_ready[0]) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || !held) $display("FAIL redir_hold: got done%b held%b want 1 1", ok, held);
    else n_pass++;
    wait_addr(0, 10'h100, 10, ok);
    n_checks++;
    if (!ok) $display("FAIL redir_target: got addr %h want 100", mem_addr[0]);
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid[0]) break;
    end
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_pc[0] !== 10'h100)
      $display("FAIL redir_first: got v%b pc %h want v1 pc 100", out_valid[0], out_pc[0]);
    else n_pass++;
  endtask

  task automatic test_redirect_copy();
    bit ok;
    int r0;
    lat_min = 3; lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_ready[0] && mem_addr[0] === 10'h105) begin ok = 1'b1; break; end
    end
    r0 = n_reads[0];
    @(posedge clk); #1 redirect[0] = 1'b1; redirect_pc[0] = 10'h105;
    @(posedge clk); #1 redirect[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (out_valid[0]) break;
    end
    n_checks++;
    if (!ok || out_valid[0] !== 1'b1 || out_pc[0] !== 10'h105 || out_instr[0] !== rom(10'h105))
      $display("FAIL copy_out: got ok%b v%b pc %h instr %h want 1 1 105 %h",
               ok, out_valid[0], out_pc[0], out_instr[0], rom(10'h105));
    else n_pass++;
    n_checks++;
    if (mem_addr[0] !== 10'h105 || n_reads[0] != r0)
      $display("FAIL copy_noread: got addr %h new reads %0d want 105 0",
               mem_addr[0], n_reads[0] - r0);
    else n_pass++;
    wait_addr(0, 10'h106, 5, ok);
    n_checks++;
    if (!ok) $display("FAIL copy_next: got addr %h want 106", mem_addr[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    lat_min = 1; lat_max = 4;
    out_ready[1] = 1'b1;
    do_reset();
    wait_ready(1, 50, ok);
    n_checks++;
    if (!ok || mem_addr[1] !== 10'h3FE)
      $display("FAIL wrap_dummy: got ok%b addr %h want 1 3fe", ok, mem_addr[1]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid[1] !== 1'b0) $display("FAIL wrap_drop: got v%b want 0", out_valid[1]);
    else n_pass++;
    wait_ready(1, 50, ok);
    n_checks++;
    if (!ok || mem_addr[1] !== 10'h3FF)
      $display("FAIL wrap_read: got ok%b addr %h want 1 3ff", ok, mem_addr[1]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid[1] !== 1'b1 || out_pc[1] !== 10'h3FF)
      $display("FAIL wrap_out: got v%b pc %h want v1 pc 3ff", out_valid[1], out_pc[1]);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (mem_addr[1] !== 10'h3FF) break;
      @(negedge clk);
    end
    n_checks++;
    if (mem_addr[1] !== 10'h000) $display("FAIL wrap_next: got addr %h want 000", mem_addr[1]);
    else n_pass++;
  endtask

  task automatic test_reset_midread();
    bit ok;
    int r0;
    lat_min = 2; lat_max = 3;
    out_ready[0] = 1'b0;
    do_reset();
    r0 = n_reads[0];
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_reads[0] - r0 == 2 && m_busy[0]) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || out_valid[0] !== 1'b1 || mem_addr[0] !== 10'd2)
      $display("FAIL rstmid_pre: got ok%b v%b addr %h want 1 1 002", ok, out_valid[0], mem_addr[0]);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid[0] !== 1'b0 || mem_addr[0] !== 10'h3FF)
      $display("FAIL rstmid_state: got v%b addr %h want v0 addr 3ff", out_valid[0], mem_addr[0]);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (mem_addr[0] !== 10'h3FF) break;
      @(negedge clk);
    end
    n_checks++;
    if (mem_addr[0] !== 10'h000) $display("FAIL rstmid_first: got addr %h want 000", mem_addr[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int h0;
    lat_min = 0; lat_max = 6;
    do_reset();
    h0 = n_hs;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        out_ready[k] = ($urandom_range(3, 0) != 0);
        redirect[k]  = ($urandom_range((k == 0) ? 15 : 40, 0) == 0);
        case ($urandom_range(3, 0))
          0:       redirect_pc[k] = m_last[k];
          1:       redirect_pc[k] = 10'h3FD + 10'($urandom_range(2, 0));
          default: redirect_pc[k] = 10'($urandom);
        endcase
      end
    end
    @(posedge clk); #1 redirect[0] = 1'b0; redirect[1] = 1'b0;
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_hs - h0 < 200) $display("FAIL rand_progress: got %0d handshakes want >=200", n_hs - h0);
    else n_pass++;
  endtask

  task automatic test_protocol();
    n_checks++;
    if (proto_err != 0) $display("FAIL mem_protocol: got %0d address changes mid-read want 0", proto_err);
    else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      redirect[k] = 1'b0; redirect_pc[k] = '0; out_ready[k] = 1'b1;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_copy();
    test_wrap();
    test_reset_midread();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
